mem_port_arbiter: RTL and testbench

//   Shares one single-port synchronous memory between the SimpleRISC_Processor

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch (IF) and
// load/store (LS) ports. One transaction is in flight at a time, and LS has priority
// over IF, limited by a starvation counter.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(MEM_LAT - 1);
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_nxt;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  logic              owner_ls, owner_ls_nxt;
  logic              owner_we, owner_we_nxt;

  logic              if_gnt_nxt, ls_gnt_nxt, if_rvalid_nxt, ls_rvalid_nxt;
  logic              mem_en_nxt, mem_we_nxt, busy_nxt;
  logic [DATA_W-1:0] if_rdata_nxt, ls_rdata_nxt, mem_wdata_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;

  logic any_req, if_wins, last_wait;

  assign any_req   = if_req | ls_req;
  assign if_wins   = if_req & (~ls_req | (starve_cnt == STARVE_LIM));
  assign last_wait = (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (last_wait) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output and for the arbitration bookkeeping.
  always_comb begin
    if_gnt_nxt    = 1'b0;
    ls_gnt_nxt    = 1'b0;
    if_rvalid_nxt = 1'b0;
    ls_rvalid_nxt = 1'b0;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    ls_rdata_nxt  = ls_rdata;
    owner_ls_nxt  = owner_ls;
    owner_we_nxt  = owner_we;
    starve_nxt    = starve_cnt;
    wait_nxt      = wait_cnt;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          mem_en_nxt = 1'b1;
          if (if_wins) begin
            if_gnt_nxt    = 1'b1;
            mem_addr_nxt  = if_addr;
            mem_wdata_nxt = '0;
            owner_ls_nxt  = 1'b0;
            owner_we_nxt  = 1'b0;
            starve_nxt    = '0;
          end else begin
            ls_gnt_nxt    = 1'b1;
            mem_we_nxt    = ls_we;
            mem_addr_nxt  = ls_addr;
            mem_wdata_nxt = ls_wdata;
            owner_ls_nxt  = 1'b1;
            owner_we_nxt  = ls_we;
            if (!if_req)
              starve_nxt = '0;
            else if (starve_cnt != STARVE_LIM)
              starve_nxt = starve_cnt + 1'b1;
          end
        end else begin
          starve_nxt = '0;
        end
      end
      ISSUE: wait_nxt = '0;
      WAIT: begin
        wait_nxt = wait_cnt + 1'b1;
        // Read data is valid on the last wait cycle; rvalid lands in the next IDLE cycle.
        if (last_wait) begin
          if (owner_ls) begin
            ls_rvalid_nxt = 1'b1;
            if (!owner_we) ls_rdata_nxt = mem_rdata;
          end else begin
            if_rvalid_nxt = 1'b1;
            if_rdata_nxt  = mem_rdata;
          end
        end
      end
      default: ;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_gnt     <= 1'b0;
      ls_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      ls_rvalid  <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      owner_ls   <= 1'b0;
      owner_we   <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      if_gnt     <= if_gnt_nxt;
      ls_gnt     <= ls_gnt_nxt;
      if_rvalid  <= if_rvalid_nxt;
      ls_rvalid  <= ls_rvalid_nxt;
      if_rdata   <= if_rdata_nxt;
      ls_rdata   <= ls_rdata_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      busy       <= busy_nxt;
      owner_ls   <= owner_ls_nxt;
      owner_we   <= owner_we_nxt;
      starve_cnt <= starve_nxt;
      wait_cnt   <= wait_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two requester agents and a memory, checked against a
// transaction-level model that predicts grant/completion times and data.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int SMAX = 4;
  localparam int NCYC = 1500;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [AW-1:0] if_addr = '0, ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] seed(input int i);
    return (i == 0) ? 32'hDEADBEEF : 32'hA5000000 + 32'(i) * 32'h01010101;
  endfunction

  // Memory: contents reload on reset; read data appears LAT cycles after the mem_en cycle.
  logic [DW-1:0] ram  [16];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= seed(i);
    end else if (mem_en && mem_we) begin
      ram[mem_addr[5:2]] <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[5:2]] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  // Transaction-level model state.
  int            next_idle, gnt_at, rv_at, starve;
  bit            tx_v, tx_ls, tx_we;
  logic [AW-1:0] tx_addr;
  logic [DW-1:0] tx_wdata, tx_rdata, if_hold, ls_hold;
  logic [DW-1:0] mmem [16];

  // Agents: index 0 = IF, 1 = LS.
  bit            act [2];
  bit            acc [2];
  int            nops [2];
  bit            a_we;
  logic [AW-1:0] a_addr [2];
  logic [DW-1:0] a_wdata;

  int ls_run, max_run, n_rst;
  bit release_rst;

  task automatic model_reset();
    tx_v = 0; next_idle = 0; starve = 0; if_hold = '0; ls_hold = '0;
    for (int i = 0; i < 16; i++) mmem[i] = seed(i);
  endtask

  task automatic new_op(input int a, input int c);
    act[a] = 1;
    if (a == 0) begin
      a_addr[0] = (nops[0] == 0) ? 32'h100 : 32'h100 + 32'($urandom_range(0, 15)) * 4;
    end else if (nops[1] == 0) begin
      a_we = 1; a_addr[1] = 32'h20; a_wdata = 32'h12345678;
    end else if (nops[1] == 1) begin
      a_we = 0; a_addr[1] = 32'h20; a_wdata = $urandom;
    end else begin
      a_we = ($urandom_range(0, 2) == 0);
      a_addr[1] = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      a_wdata = $urandom;
    end
    nops[a]++;
  endtask

  initial begin
    bit e_en, if_w;
    int prob;
    model_reset();
    act[0] = 0; act[1] = 0; acc[0] = 0; acc[1] = 0; nops[0] = 0; nops[1] = 0;
    ls_run = 0; max_run = 0; n_rst = 0; release_rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy}), 64'd0);
    chk("rst_data", 64'(if_rdata | ls_rdata | mem_addr | mem_wdata), 64'd0);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      // Compare this cycle's registered outputs with the model.
      if (tx_v && c == rv_at && !tx_we) begin
        if (tx_ls) ls_hold = tx_rdata;
        else       if_hold = tx_rdata;
      end
      e_en = tx_v && c == gnt_at;
      chk("if_gnt", 64'(if_gnt), 64'(e_en && !tx_ls));
      chk("ls_gnt", 64'(ls_gnt), 64'(e_en && tx_ls));
      chk("mem_en", 64'(mem_en), 64'(e_en));
      chk("busy", 64'(busy), 64'(tx_v && c >= gnt_at && c < rv_at));
      chk("if_rvalid", 64'(if_rvalid), 64'(tx_v && c == rv_at && !tx_ls));
      chk("ls_rvalid", 64'(ls_rvalid), 64'(tx_v && c == rv_at && tx_ls));
      chk("if_rdata", 64'(if_rdata), 64'(if_hold));
      chk("ls_rdata", 64'(ls_rdata), 64'(ls_hold));
      if (e_en) begin
        chk("mem_we", 64'(mem_we), 64'(tx_we));
        chk("mem_addr", 64'(mem_addr), 64'(tx_addr));
        if (tx_we) chk("mem_wdata", 64'(mem_wdata), 64'(tx_wdata));
      end
      if (tx_v && c == rv_at) tx_v = 0;

      if (c >= 400 && c < 600) begin
        if (ls_gnt) ls_run++;
        if (if_gnt) ls_run = 0;
        if (ls_run > max_run) max_run = ls_run;
      end

      if (release_rst) begin
        rst = 0;
        release_rst = 0;
      end

      // Occasionally reset while a transaction is waiting on memory.
      if (c >= 800 && n_rst < 4 && tx_v && c > gnt_at && c < rv_at && $urandom_range(0, 3) == 0) begin
        #2 rst = 1;
        #1;
        chk("rst_ctl_mid", 64'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy}), 64'd0);
        chk("rst_data_mid", 64'(if_rdata | ls_rdata | mem_addr | mem_wdata), 64'd0);
        model_reset();
        n_rst++;
        release_rst = 1;
        continue;
      end

      // Agents: drop after acceptance, possibly start a new request at once.
      prob = (c >= 400 && c < 600) ? 100 : 35;
      for (int a = 0; a < 2; a++) begin
        if (acc[a]) begin act[a] = 0; acc[a] = 0; end
        if (!act[a] && (nops[a] < 2 || $urandom_range(0, 99) < prob)) new_op(a, c);
      end
      if_req = act[0]; if_addr = a_addr[0];
      ls_req = act[1]; ls_we = a_we; ls_addr = a_addr[1]; ls_wdata = a_wdata;

      // Arbitration decision in an idle cycle.
      if (c >= next_idle) begin
        if (act[0] || act[1]) begin
          if_w = act[0] && (!act[1] || starve == SMAX);
          if (if_w) starve = 0;
          else if (act[0]) starve = (starve < SMAX) ? starve + 1 : SMAX;
          else starve = 0;
          tx_v = 1; tx_ls = !if_w; tx_we = if_w ? 1'b0 : a_we;
          tx_addr = if_w ? a_addr[0] : a_addr[1];
          tx_wdata = a_wdata;
          if (tx_we) mmem[tx_addr[5:2]] = tx_wdata;
          tx_rdata = mmem[tx_addr[5:2]];
          gnt_at = c + 1; rv_at = c + 2 + LAT; next_idle = rv_at;
          acc[if_w ? 0 : 1] = 1;
        end else begin
          starve = 0;
        end
      end
    end

    chk("starve_max_run", 64'(max_run), 64'(SMAX));
    chk("mid_resets", 64'(n_rst > 0), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
